seq_alu: RTL and testbench

Parametrised, handshaked successor to the single-cycle 16-bit datapath ALU, for the execute stage.
- Single-cycle logic, arithmetic, shift/rotate and bit-reverse ops.
- Iterative multi-cycle unsigned multiply and divide.
- valid/ready on both input and output, so the pipeline can stall on long ops.
- Result plus zero/overflow/carry/negative flags.

---
 rtl/seq_alu.sv | 235 +++++++++++++++++++++++
 tb/tb_seq_alu.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: single-cycle logic/arith/shift ops plus iterative MULU/DIVU.
// Optional divider hardware is built only when SEQ_ALU_DIV_EN is defined; otherwise DIVU is illegal.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             ofl,
    output logic             cout,
    output logic             neg,
    output logic             err
);

    // state | meaning
    // IDLE  | waiting for an op, in_ready high
    // BUSY  | MULU/DIVU iterating, one bit per cycle
    // DONE  | result held until out_ready
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_ROR  = 4'd9;
    localparam logic [3:0] OP_BTR  = 4'd10;
    localparam logic [3:0] OP_MULU = 4'd11;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'd12;
`endif

    localparam logic [SHW:0] ITER_LOAD = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] ITER_ONE  = (SHW+1)'(1);

    state_t             state;
    logic [SHW:0]       iter_cnt;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
`ifdef SEQ_ALU_DIV_EN
    logic [WIDTH-1:0]   divisor_q;
    logic               div_q;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
`endif

    logic [WIDTH-1:0]   sc_res;
    logic               sc_cout;
    logic               sc_ofl;
    logic               sc_err;
    logic [WIDTH:0]     sc_sum;
    logic [2*WIDTH-1:0] sc_dbl;
    logic [SHW-1:0]     sh;
    logic               is_iter;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   nxt_hi;
    logic [WIDTH-1:0]   nxt_lo;

    assign in_ready = (state == S_IDLE);
    assign sh       = b[SHW-1:0];

    always_comb begin
        sc_res  = '0;
        sc_cout = 1'b0;
        sc_ofl  = 1'b0;
        sc_err  = 1'b0;
        sc_sum  = '0;
        sc_dbl  = '0;
        is_iter = 1'b0;
        case (op)
            OP_ADD: begin
                sc_sum  = {1'b0, a} + {1'b0, b};
                sc_res  = sc_sum[WIDTH-1:0];
                sc_cout = sc_sum[WIDTH];
                sc_ofl  = (a[WIDTH-1] == b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_sum  = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                sc_res  = sc_sum[WIDTH-1:0];
                sc_cout = sc_sum[WIDTH];
                sc_ofl  = (a[WIDTH-1] != b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_XOR: sc_res = a ^ b;
            OP_SLL: sc_res = a << sh;
            OP_SRL: sc_res = a >> sh;
            OP_SRA: sc_res = $unsigned($signed(a) >>> sh);
            // Rotates work on a doubled copy so a zero amount needs no special case.
            OP_ROL: begin
                sc_dbl = {a, a} << sh;
                sc_res = sc_dbl[2*WIDTH-1:WIDTH];
            end
            OP_ROR: begin
                sc_dbl = {a, a} >> sh;
                sc_res = sc_dbl[WIDTH-1:0];
            end
            OP_BTR: begin
                for (int i = 0; i < WIDTH; i++) sc_res[i] = a[WIDTH-1-i];
            end
            OP_MULU: is_iter = 1'b1;
`ifdef SEQ_ALU_DIV_EN
            OP_DIVU: is_iter = 1'b1;
`endif
            default: sc_err = 1'b1;
        endcase
    end

    // One iteration step; the last step feeds the registered result directly.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand_q} : '0);
        nxt_hi  = mul_sum[WIDTH:1];
        nxt_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift[WIDTH-1:0] - divisor_q;
        if (div_q) begin
            if (div_shift >= {1'b0, divisor_q}) begin
                nxt_hi = div_diff;
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = div_shift[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            iter_cnt  <= '0;
            mcand_q   <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            ofl       <= 1'b0;
            cout      <= 1'b0;
            neg       <= 1'b0;
            err       <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            divisor_q <= '0;
            div_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_iter) begin
                            state    <= S_BUSY;
                            iter_cnt <= ITER_LOAD;
                            mcand_q  <= a;
                            acc_hi   <= '0;
`ifdef SEQ_ALU_DIV_EN
                            acc_lo    <= (op == OP_DIVU) ? a : b;
                            divisor_q <= b;
                            div_q     <= (op == OP_DIVU);
`else
                            acc_lo   <= b;
`endif
                        end else begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            result    <= sc_res;
                            result_hi <= '0;
                            zero      <= (sc_res == '0);
                            neg       <= sc_res[WIDTH-1];
                            ofl       <= sc_ofl;
                            cout      <= sc_cout;
                            err       <= sc_err;
                        end
                    end
                end
                S_BUSY: begin
                    acc_hi   <= nxt_hi;
                    acc_lo   <= nxt_lo;
                    iter_cnt <= iter_cnt - ITER_ONE;
                    if (iter_cnt == ITER_ONE) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= nxt_lo;
                        result_hi <= nxt_hi;
                        zero      <= (nxt_lo == '0);
                        neg       <= nxt_lo[WIDTH-1];
                        ofl       <= (nxt_hi != '0);
                        cout      <= 1'b0;
                        err       <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
                        if (div_q) begin
                            ofl <= 1'b0;
                            if (divisor_q == '0) begin
                                result    <= '1;
                                result_hi <= mcand_q;
                                zero      <= 1'b0;
                                neg       <= 1'b1;
                                err       <= 1'b1;
                            end
                        end
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised self-checking bench for seq_alu against an arithmetic reference model.
// Expectations for DIVU follow SEQ_ALU_DIV_EN, matching the build of the design.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [15:0] a = 16'd0;
    logic [15:0] b = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic [15:0] result_hi;
    logic        zero, ofl, cout, neg, err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] res;
        logic [15:0] hi;
        logic        zero;
        logic        ofl;
        logic        cout;
        logic        neg;
        logic        err;
        int          lat;
    } exp_t;

    seq_alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .ofl       (ofl),
        .cout      (cout),
        .neg       (neg),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int o, input int x, input int y);
        exp_t e;
        int s, sx, sy, sh, r;
        longint p;
        e.res = 16'd0; e.hi = 16'd0; e.ofl = 1'b0; e.cout = 1'b0; e.err = 1'b0; e.lat = 1;
        sh = y % 16;
        sx = (x >= 32768) ? x - 65536 : x;
        sy = (y >= 32768) ? y - 65536 : y;
        case (o)
            0: begin
                s = x + y; e.res = 16'(s); e.cout = (s > 65535);
                e.ofl = (sx + sy > 32767) || (sx + sy < -32768);
            end
            1: begin
                s = x - y; e.res = 16'(s); e.cout = (x >= y);
                e.ofl = (sx - sy > 32767) || (sx - sy < -32768);
            end
            2: e.res = 16'(x & y);
            3: e.res = 16'(x | y);
            4: e.res = 16'(x ^ y);
            5: e.res = 16'(x << sh);
            6: e.res = 16'(x >> sh);
            7: e.res = 16'(sx >>> sh);
            8: begin r = (sh == 0) ? x : ((x << sh) | (x >> (16 - sh))); e.res = 16'(r); end
            9: begin r = (sh == 0) ? x : ((x >> sh) | (x << (16 - sh))); e.res = 16'(r); end
            10: begin
                r = 0;
                for (int i = 0; i < 16; i++) if (((x >> (15 - i)) & 1) != 0) r = r | (1 << i);
                e.res = 16'(r);
            end
            11: begin
                p = longint'(x) * longint'(y);
                e.res = 16'(p); e.hi = 16'(p >> 16); e.ofl = (e.hi != 16'd0); e.lat = 17;
            end
`ifdef SEQ_ALU_DIV_EN
            12: begin
                e.lat = 17;
                if (y == 0) begin e.res = 16'hFFFF; e.hi = 16'(x); e.err = 1'b1; end
                else begin e.res = 16'(x / y); e.hi = 16'(x % y); end
            end
`endif
            default: e.err = 1'b1;
        endcase
        e.zero = (e.res == 16'd0);
        e.neg  = e.res[15];
        return e;
    endfunction

    task automatic check_out(input exp_t e);
        chk("result",    32'(result),    32'(e.res));
        chk("result_hi", 32'(result_hi), 32'(e.hi));
        chk("zero",      32'(zero),      32'(e.zero));
        chk("ofl",       32'(ofl),       32'(e.ofl));
        chk("cout",      32'(cout),      32'(e.cout));
        chk("neg",       32'(neg),       32'(e.neg));
        chk("err",       32'(err),       32'(e.err));
    endtask

    // Issue one op, wait for its result with junk traffic on the input, hold it `stall` cycles, then drain.
    task automatic run_op(input logic [3:0] o, input logic [15:0] xa, input logic [15:0] xb, input int stall);
        exp_t e;
        int n;
        e = model(int'(o), int'(xa), int'(xb));
        @(negedge clk);
        in_valid = 1'b1; op = o; a = xa; b = xb;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); op = 4'($urandom);
        n = 1;
        while (!out_valid && n < 40) begin
            chk("in_ready_busy", 32'(in_ready), 32'd0);
            in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom); op = 4'($urandom);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(e.lat));
        if (!out_valid) return;
        for (int k = 0; k <= stall; k++) begin
            check_out(e);
            chk("in_ready_done", 32'(in_ready), 32'd0);
            chk("out_valid_hold", 32'(out_valid), 32'd1);
            if (k < stall) begin
                in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_clr", 32'(out_valid), 32'd0);
        chk("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ro;
        logic [15:0] ra, rb;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    32'(result),    32'd0);
        chk("rst_result_hi", 32'(result_hi), 32'd0);
        chk("rst_flags",     32'({zero, ofl, cout, neg, err}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd0,  16'h7FFF, 16'h0001, 0);
        run_op(4'd1,  16'h0005, 16'h0005, 0);
        run_op(4'd1,  16'h0000, 16'h0001, 0);
        run_op(4'd8,  16'h8001, 16'h0004, 0);
        run_op(4'd7,  16'h8000, 16'h0003, 0);
        run_op(4'd6,  16'h8000, 16'h000F, 0);
        run_op(4'd10, 16'h0001, 16'h0000, 0);
        run_op(4'd9,  16'h0001, 16'h0001, 0);
        run_op(4'd8,  16'hA5C3, 16'h0010, 0);
        run_op(4'd11, 16'h0100, 16'h0100, 0);
        run_op(4'd11, 16'hFFFF, 16'hFFFF, 1);
        run_op(4'd12, 16'd100,  16'd7,    0);
        run_op(4'd12, 16'h1234, 16'h0000, 0);
        run_op(4'd13, 16'h1234, 16'h5678, 0);
        run_op(4'd15, 16'h0000, 16'h0000, 0);
        run_op(4'd0,  16'h1234, 16'h1111, 3);

        // Reset during cycle 5 of a MULU must clear everything without a clock edge.
        @(negedge clk);
        in_valid = 1'b1; op = 4'd11; a = 16'h0100; b = 16'h0300;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("busy_before_rst", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_result",    32'(result),    32'd0);
        chk("midrst_result_hi", 32'(result_hi), 32'd0);
        chk("midrst_flags",     32'({zero, ofl, cout, neg, err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd0, 16'h0003, 16'h0004, 0);

        for (int t = 0; t < 80; t++) begin
            ro = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            run_op(ro, ra, rb, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
